// File: rtl/attention_feeder_if.sv
// Stream-side handshakes of attention_feeder: element input and result output.
// slave is the feeder's view; master is the upstream/downstream view.
interface attention_feeder_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_timeout;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_timeout
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_timeout
    );
endinterface

// File: rtl/attention_feeder.sv
// Assembles Q/K/V vectors from a serial Q8.8 stream, starts the attention core,
// and returns its scalar result (or a timeout-forced zero) over a handshake.
module attention_feeder #(
    parameter int N       = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    attention_feeder_if.slave    bus,
    output logic [N-1:0][DW-1:0] q_out,
    output logic [N-1:0][DW-1:0] k_out,
    output logic [N-1:0][DW-1:0] v_out,
    output logic                 core_start,
    input  logic                 core_done,
    input  logic [DW-1:0]        core_y,
    output logic                 busy
);
    localparam int CW = $clog2(3 * N);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(3 * N - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT, HOLD} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_timeout;

    assign bus.in_ready    = (state == LOAD);
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data;
    assign bus.out_timeout = out_timeout;
    assign busy            = (state != LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOAD;
            cnt         <= '0;
            timer       <= '0;
            q_out       <= '0;
            k_out       <= '0;
            v_out       <= '0;
            core_start  <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_timeout <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        // Element slot decoded by compare rather than indexing with the wider cnt.
                        for (int unsigned i = 0; i < N; i++) begin
                            if (cnt == CW'(i))         q_out[i] <= bus.in_data;
                            if (cnt == CW'(N + i))     k_out[i] <= bus.in_data;
                            if (cnt == CW'(2 * N + i)) v_out[i] <= bus.in_data;
                        end
                        if (cnt == CNT_LAST) begin
                            cnt        <= '0;
                            core_start <= 1'b1;
                            state      <= FIRE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    core_start <= 1'b0;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) begin
                        out_data    <= core_y;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else if (timer == TMR_LAST) begin
                        out_data    <= '0;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_attention_feeder.sv
// Scoreboard bench for attention_feeder: stimulus queues expected vectors/results,
// a monitor checks them as the DUT presents core_start and out_valid.
module tb_attention_feeder;
    localparam int N       = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    attention_feeder_if #(.DW(DW)) bus ();

    logic [N-1:0][DW-1:0] q_out, k_out, v_out;
    logic          core_start, core_done, busy;
    logic [DW-1:0] core_y = 16'h5A5A;
    logic          model_done = 1'b0;
    logic          spur_done  = 1'b0;
    assign core_done = model_done | spur_done;

    attention_feeder #(.N(N), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .q_out      (q_out),
        .k_out      (k_out),
        .v_out      (v_out),
        .core_start (core_start),
        .core_done  (core_done),
        .core_y     (core_y),
        .busy       (busy)
    );

    typedef struct {
        logic [DW-1:0] q[N];
        logic [DW-1:0] k[N];
        logic [DW-1:0] v[N];
        int            lat;       // core done latency in cycles after start edge; -1 = never
        logic [DW-1:0] y;
        logic [DW-1:0] exp_data;
        logic          exp_to;
        int            exp_lat;   // cycles from core_start to out_valid rising
    } item_t;

    item_t exp_q[$];
    int checks   = 0;
    int errors   = 0;
    int n_starts = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic give_up(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic item_t mk(input logic [DW-1:0] qb, kb, vb, input int step, input int lat,
                                 input logic [DW-1:0] y, ed, input logic eto, input int elat);
        item_t it;
        for (int i = 0; i < N; i++) begin
            it.q[i] = qb + DW'(step * i);
            it.k[i] = kb + DW'(step * i);
            it.v[i] = vb + DW'(step * i);
        end
        it.lat = lat; it.y = y; it.exp_data = ed; it.exp_to = eto; it.exp_lat = elat;
        return it;
    endfunction

    task automatic send_elem(input logic [DW-1:0] d, input int gap);
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = DW'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int n = 0; !bus.in_ready; n++) begin
            if (n >= 300) give_up("in_ready_wait");
            @(negedge clk);
        end
    endtask

    task automatic send_vec(input item_t it, input bit gaps, input bit chain);
        logic [DW-1:0] d;
        exp_q.push_back(it);
        for (int i = 0; i < 3 * N; i++) begin
            if (i < N)          d = it.q[i];
            else if (i < 2 * N) d = it.k[i - N];
            else                d = it.v[i - 2 * N];
            send_elem(d, (gaps && i != 0) ? int'($urandom_range(0, 2)) : 0);
        end
        if (!chain) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 400);
        if (n >= 400) give_up("idle_wait");
    endtask

    // Core model: done for one cycle, lat cycles after the edge that samples core_start.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && core_start && exp_q.size() > 0) begin
                int lat;
                logic [DW-1:0] y;
                lat = exp_q[0].lat;
                y   = exp_q[0].y;
                if (lat >= 0) begin
                    repeat (lat + 1) @(posedge clk);
                    #1 model_done = 1'b1;
                    core_y = y;
                    @(posedge clk);
                    #1 model_done = 1'b0;
                end
            end
        end
    end

    // Monitor / scoreboard and downstream ready policy.
    initial begin
        logic prev_ov, prev_or, prev_cs, prev_ot, in_txn;
        logic [DW-1:0] prev_od;
        int cyc, start_cyc, hold;
        item_t it;
        prev_ov = 0; prev_or = 0; prev_cs = 0; prev_ot = 0; in_txn = 0; prev_od = '0;
        cyc = 0; start_cyc = 0; hold = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                prev_ov = 0; prev_or = 0; prev_cs = 0; in_txn = 0; hold = 0;
                bus.out_ready = 1'b0;
                continue;
            end
            if (prev_ov && !bus.out_valid) in_txn = 0;
            if (core_start) begin
                chk("core_start_width", prev_cs, 0);
                n_starts++;
                start_cyc = cyc;
                in_txn = 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_core_start", 1, 0);
                end else begin
                    for (int i = 0; i < N; i++) begin
                        chk($sformatf("q_out[%0d]", i), q_out[i], exp_q[0].q[i]);
                        chk($sformatf("k_out[%0d]", i), k_out[i], exp_q[0].k[i]);
                        chk($sformatf("v_out[%0d]", i), v_out[i], exp_q[0].v[i]);
                    end
                end
            end
            if (in_txn) begin
                chk("in_ready_outside_load", bus.in_ready, 0);
                chk("busy_outside_load", busy, 1);
            end
            if (bus.out_valid && !prev_ov) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("out_data", bus.out_data, it.exp_data);
                    chk("out_timeout", bus.out_timeout, it.exp_to);
                    chk("result_latency", 64'(cyc - start_cyc), 64'(it.exp_lat));
                end
            end else if (bus.out_valid && prev_ov && !prev_or) begin
                chk("out_data_hold", bus.out_data, prev_od);
                chk("out_timeout_hold", bus.out_timeout, prev_ot);
            end
            if (prev_ov && prev_or) chk("out_valid_clear", bus.out_valid, 0);
            if (bus.out_valid) hold++;
            else hold = 0;
            bus.out_ready = bus.out_valid && (hold > 5);
            prev_ov = bus.out_valid;
            prev_or = bus.out_ready;
            prev_cs = core_start;
            prev_od = bus.out_data;
            prev_ot = bus.out_timeout;
        end
    end

    initial begin
        #200000;
        give_up("global_watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_timeout", bus.out_timeout, 0);
        chk("rst_q_out", q_out, 0);
        chk("rst_k_out", k_out, 0);
        chk("rst_v_out", v_out, 0);

        // Spurious done while loading is ignored.
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_load_busy", busy, 0);
        chk("spur_load_in_ready", bus.in_ready, 1);

        // Basic vector, native core latency.
        send_vec(mk(16'h0100, 16'h0080, 16'h0200, 0, 2, 16'h0123, 16'h0123, 1'b0, 4), 1'b0, 1'b0);
        wait_idle();

        // Spurious done during HOLD.
        send_vec(mk(16'h1000, 16'h2000, 16'h3000, 1, 2, 16'h7ABC, 16'h7ABC, 1'b0, 4), 1'b0, 1'b0);
        for (int n = 0; !bus.out_valid; n++) begin
            if (n >= 50) give_up("out_valid_wait");
            @(negedge clk);
        end
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        wait_idle();

        // Gapped stream, then the next vector waiting with in_valid high through WAIT/HOLD.
        send_vec(mk(16'h0011, 16'h0022, 16'h0033, 16'h0100, 2, 16'hFEDC, 16'hFEDC, 1'b0, 4), 1'b1, 1'b1);
        send_vec(mk(16'hA000, 16'hB000, 16'hC000, 1, 2, 16'h8001, 16'h8001, 1'b0, 4), 1'b1, 1'b0);
        wait_idle();

        // No done at all: forced zero result after TIMEOUT wait cycles.
        send_vec(mk(16'h0F00, 16'h0E00, 16'h0D00, 2, -1, 16'h0000, 16'h0000, 1'b1, TIMEOUT + 1), 1'b0, 1'b0);
        wait_idle();

        // Done in the final wait cycle wins over timeout.
        send_vec(mk(16'h4000, 16'h5000, 16'h6000, 3, TIMEOUT - 1, 16'h1357, 16'h1357, 1'b0, TIMEOUT + 1), 1'b0, 1'b0);
        wait_idle();

        // Reset asserted in WAIT clears everything at once.
        send_vec(mk(16'h7777, 16'h6666, 16'h5555, 1, -1, 16'h0000, 16'h0000, 1'b0, 0), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_core_start", core_start, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        chk("mid_rst_q_out", q_out, 0);
        chk("mid_rst_v_out", v_out, 0);
        void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;

        send_vec(mk(16'h0101, 16'h0202, 16'h0303, 1, 2, 16'h0246, 16'h0246, 1'b0, 4), 1'b0, 1'b0);
        wait_idle();

        chk("core_start_count", 64'(n_starts), 64'd8);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
